// File: rtl/execute_stage.sv
// Execute stage: ALU, beq/bneq resolution and an iterative shift-add
// multiplier, with the execute/memory boundary register built in.
module execute_stage #(
    parameter int DATAPATH_WIDTH     = 64,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int INST_ADDR_WIDTH    = 9
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [INST_ADDR_WIDTH-1:0]    pc_in,
    input  logic [DATAPATH_WIDTH-1:0]     R1_data_in,
    input  logic [DATAPATH_WIDTH-1:0]     R2_data_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
    input  logic [3:0]                    alu_ctrl_in,
    input  logic                          WR_en_in,
    input  logic                          mem_reg_sel_in,
    input  logic                          beq_in,
    input  logic                          bneq_in,
    input  logic                          mem_write_in,
    input  logic [INST_ADDR_WIDTH-1:0]    branch_offset_in,
    output logic                          stall_out,
    output logic [DATAPATH_WIDTH-1:0]     alu_result_out,
    output logic [DATAPATH_WIDTH-1:0]     store_data_out,
    output logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out,
    output logic                          WR_en_out,
    output logic                          mem_reg_sel_out,
    output logic                          mem_write_out,
    output logic                          branch_taken_out,
    output logic [INST_ADDR_WIDTH-1:0]    branch_target_out
);

    localparam int SHAMT_WIDTH = $clog2(DATAPATH_WIDTH);
    localparam logic [SHAMT_WIDTH-1:0] LAST_COUNT = SHAMT_WIDTH'(DATAPATH_WIDTH - 1);

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_NOR    = 4'd5,
        ALU_SLL    = 4'd6,
        ALU_SRL    = 4'd7,
        ALU_SRA    = 4'd8,
        ALU_SLT    = 4'd9,
        ALU_SLTU   = 4'd10,
        ALU_MUL    = 4'd11,
        ALU_PASS_A = 4'd12,
        ALU_PASS_B = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Multiplier working registers (operands latched so upstream changes cannot corrupt them)
    logic [DATAPATH_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATAPATH_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATAPATH_WIDTH-1:0] acc_q, acc_d;
    logic [SHAMT_WIDTH-1:0]    count_q, count_d;

    // Execute/memory boundary register
    logic [DATAPATH_WIDTH-1:0]     alu_result_q, alu_result_d;
    logic [DATAPATH_WIDTH-1:0]     store_data_q, store_data_d;
    logic [REGFILE_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                          wr_en_q, wr_en_d;
    logic                          mem_reg_sel_q, mem_reg_sel_d;
    logic                          mem_write_q, mem_write_d;
    logic                          branch_taken_q, branch_taken_d;
    logic [INST_ADDR_WIDTH-1:0]    branch_target_q, branch_target_d;

    logic [DATAPATH_WIDTH-1:0] alu_res;
    logic [SHAMT_WIDTH-1:0]    shamt;
    logic                      slt_bit;
    logic                      taken;
    logic                      is_mul;
    logic                      stall;

    assign shamt  = R2_data_in[SHAMT_WIDTH-1:0];
    assign is_mul = (alu_ctrl_in == ALU_MUL);
    assign taken  = (beq_in & (R1_data_in == R2_data_in)) |
                    (bneq_in & (R1_data_in != R2_data_in));

    // Single-cycle ALU result for every non-MUL operation
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_res = '0;
        slt_bit = 1'b0;
        case (alu_ctrl_in)
            ALU_ADD:    alu_res = R1_data_in + R2_data_in;
            ALU_SUB:    alu_res = R1_data_in - R2_data_in;
            ALU_AND:    alu_res = R1_data_in & R2_data_in;
            ALU_OR:     alu_res = R1_data_in | R2_data_in;
            ALU_XOR:    alu_res = R1_data_in ^ R2_data_in;
            ALU_NOR:    alu_res = ~(R1_data_in | R2_data_in);
            ALU_SLL:    alu_res = R1_data_in << shamt;
            ALU_SRL:    alu_res = R1_data_in >> shamt;
            ALU_SRA:    alu_res = $unsigned($signed(R1_data_in) >>> shamt);
            ALU_SLT: begin
                slt_bit = ($signed(R1_data_in) < $signed(R2_data_in));
                alu_res = {{(DATAPATH_WIDTH-1){1'b0}}, slt_bit};
            end
            ALU_SLTU: begin
                slt_bit = (R1_data_in < R2_data_in);
                alu_res = {{(DATAPATH_WIDTH-1){1'b0}}, slt_bit};
            end
            ALU_PASS_A: alu_res = R1_data_in;
            ALU_PASS_B: alu_res = R2_data_in;
            default:    alu_res = '0;
        endcase
    end

    // Next-state, multiplier datapath and boundary-register inputs
    always_comb begin
        state_d         = state_q;
        mcand_d         = mcand_q;
        mplier_d        = mplier_q;
        acc_d           = acc_q;
        count_d         = count_q;
        stall           = 1'b0;
        // Defaults describe a bubble: data fields hold, controls drop to 0.
        alu_result_d    = alu_result_q;
        store_data_d    = store_data_q;
        wr_addr_d       = wr_addr_q;
        branch_target_d = branch_target_q;
        wr_en_d         = 1'b0;
        mem_reg_sel_d   = 1'b0;
        mem_write_d     = 1'b0;
        branch_taken_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_mul) begin
                    stall    = 1'b1;
                    mcand_d  = R1_data_in;
                    mplier_d = R2_data_in;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = MUL_BUSY;
                end else begin
                    alu_result_d    = alu_res;
                    store_data_d    = R2_data_in;
                    wr_addr_d       = WR_addr_in;
                    wr_en_d         = WR_en_in;
                    mem_reg_sel_d   = mem_reg_sel_in;
                    mem_write_d     = mem_write_in;
                    branch_taken_d  = taken;
                    branch_target_d = pc_in + branch_offset_in;
                end
            end
            MUL_BUSY: begin
                stall = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + SHAMT_WIDTH'(1);
                if (count_q == LAST_COUNT) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                // Branch evaluation is masked for MUL; controls come from the held instruction.
                alu_result_d    = acc_q;
                store_data_d    = R2_data_in;
                wr_addr_d       = WR_addr_in;
                wr_en_d         = WR_en_in;
                mem_reg_sel_d   = mem_reg_sel_in;
                mem_write_d     = mem_write_in;
                branch_target_d = pc_in + branch_offset_in;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold request is suppressed while reset is high
    assign stall_out = stall & ~reset;

    // State, multiplier and boundary registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
        if (reset) begin
            state_q         <= IDLE;
            mcand_q         <= '0;
            mplier_q        <= '0;
            acc_q           <= '0;
            count_q         <= '0;
            alu_result_q    <= '0;
            store_data_q    <= '0;
            wr_addr_q       <= '0;
            wr_en_q         <= 1'b0;
            mem_reg_sel_q   <= 1'b0;
            mem_write_q     <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
        end else begin
            state_q         <= state_d;
            mcand_q         <= mcand_d;
            mplier_q        <= mplier_d;
            acc_q           <= acc_d;
            count_q         <= count_d;
            alu_result_q    <= alu_result_d;
            store_data_q    <= store_data_d;
            wr_addr_q       <= wr_addr_d;
            wr_en_q         <= wr_en_d;
            mem_reg_sel_q   <= mem_reg_sel_d;
            mem_write_q     <= mem_write_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
        end
    end

    assign alu_result_out    = alu_result_q;
    assign store_data_out    = store_data_q;
    assign WR_addr_out       = wr_addr_q;
    assign WR_en_out         = wr_en_q;
    assign mem_reg_sel_out   = mem_reg_sel_q;
    assign mem_write_out     = mem_write_q;
    assign branch_taken_out  = branch_taken_q;
    assign branch_target_out = branch_target_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed corner cases plus random
// instruction stream scored against a behavioural model.
module tb_execute_stage;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int IW = 9;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd11;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] pc_in;
    logic [DW-1:0] R1_data_in, R2_data_in;
    logic [AW-1:0] WR_addr_in;
    logic [3:0]    alu_ctrl_in;
    logic          WR_en_in, mem_reg_sel_in, beq_in, bneq_in, mem_write_in;
    logic [IW-1:0] branch_offset_in;
    logic          stall_out;
    logic [DW-1:0] alu_result_out, store_data_out;
    logic [AW-1:0] WR_addr_out;
    logic          WR_en_out, mem_reg_sel_out, mem_write_out, branch_taken_out;
    logic [IW-1:0] branch_target_out;

    int checks = 0;
    int errors = 0;

    // Model view of the boundary register
    logic [DW-1:0] exp_res, exp_store;
    logic [AW-1:0] exp_wa;
    logic          exp_we, exp_ms, exp_mw, exp_taken;
    logic [IW-1:0] exp_tgt;
    bit            side_known;

    execute_stage #(
        .DATAPATH_WIDTH(DW), .REGFILE_ADDR_WIDTH(AW), .INST_ADDR_WIDTH(IW)
    ) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in),
        .R1_data_in(R1_data_in), .R2_data_in(R2_data_in),
        .WR_addr_in(WR_addr_in), .alu_ctrl_in(alu_ctrl_in),
        .WR_en_in(WR_en_in), .mem_reg_sel_in(mem_reg_sel_in),
        .beq_in(beq_in), .bneq_in(bneq_in), .mem_write_in(mem_write_in),
        .branch_offset_in(branch_offset_in), .stall_out(stall_out),
        .alu_result_out(alu_result_out), .store_data_out(store_data_out),
        .WR_addr_out(WR_addr_out), .WR_en_out(WR_en_out),
        .mem_reg_sel_out(mem_reg_sel_out), .mem_write_out(mem_write_out),
        .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference ALU from the operation definitions
    function automatic logic [DW-1:0] model_alu(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int unsigned sh;
        logic [DW-1:0] sign_flip;
        logic [DW-1:0] ones;
        logic [DW-1:0] r;
        sh        = b % DW;
        sign_flip = 1;
        sign_flip = sign_flip << (DW - 1);
        ones      = '1;
        case (c)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~(a | b);
            4'd6:  r = a << sh;
            4'd7:  r = a >> sh;
            4'd8: begin
                r = a >> sh;
                if (a[DW-1]) r = r | ~(ones >> sh);
            end
            4'd9:  r = ((a ^ sign_flip) < (b ^ sign_flip)) ? 1 : 0;
            4'd10: r = (a < b) ? 1 : 0;
            4'd11: r = a * b;
            4'd12: r = a;
            4'd13: r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_res"}, alu_result_out, exp_res);
        check({tag, "_wa"}, DW'(WR_addr_out), DW'(exp_wa));
        check({tag, "_we"}, DW'(WR_en_out), DW'(exp_we));
        check({tag, "_ms"}, DW'(mem_reg_sel_out), DW'(exp_ms));
        check({tag, "_mw"}, DW'(mem_write_out), DW'(exp_mw));
        check({tag, "_taken"}, DW'(branch_taken_out), DW'(exp_taken));
        if (side_known) begin
            check({tag, "_store"}, store_data_out, exp_store);
            check({tag, "_tgt"}, DW'(branch_target_out), DW'(exp_tgt));
        end
    endtask

    task automatic model_reset();
        exp_res = '0; exp_store = '0; exp_wa = '0; exp_we = 0; exp_ms = 0;
        exp_mw = 0; exp_taken = 0; exp_tgt = '0; side_known = 1;
    endtask

    // Entered and left at a falling edge; applies one instruction and scores it.
    task automatic exec_op(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [AW-1:0] wa, input logic we, input logic ms, input logic mw,
                           input logic bq, input logic bn, input logic [IW-1:0] pc,
                           input logic [IW-1:0] off, input bit scramble);
        int n;
        alu_ctrl_in = c; R1_data_in = a; R2_data_in = b; WR_addr_in = wa;
        WR_en_in = we; mem_reg_sel_in = ms; mem_write_in = mw;
        beq_in = bq; bneq_in = bn; pc_in = pc; branch_offset_in = off;
        #1;
        if (c == OP_MUL) begin
            check("mul_stall_start", DW'(stall_out), DW'(1'b1));
            exp_we = 0; exp_ms = 0; exp_mw = 0; exp_taken = 0;
            n = 0;
            while (stall_out === 1'b1 && n < 200) begin
                n++;
                @(negedge clk);
                check_outputs("mul_bubble");
                if (scramble) begin
                    R1_data_in = {$urandom, $urandom};
                    R2_data_in = {$urandom, $urandom};
                end
                #1;
            end
            check("mul_stall_len", DW'(n), DW'(DW + 1));
            R1_data_in = a; R2_data_in = b;
            @(negedge clk);
            exp_res = a * b; exp_wa = wa; exp_we = we; exp_ms = ms; exp_mw = mw;
            exp_taken = 0; side_known = 0;
            check_outputs("mul_result");
        end else begin
            check("stall_low", DW'(stall_out), DW'(1'b0));
            @(negedge clk);
            exp_res = model_alu(c, a, b); exp_store = b; exp_wa = wa; exp_we = we;
            exp_ms = ms; exp_mw = mw; exp_tgt = pc + off;
            exp_taken = (bq && a == b) || (bn && a != b);
            side_known = 1;
            check_outputs("alu");
        end
    endtask

    initial begin
        logic [3:0]    rc;
        logic [DW-1:0] ra, rb;

        // Reset with a MUL presented: outputs 0 and no hold request
        reset = 1;
        alu_ctrl_in = OP_MUL; R1_data_in = {$urandom, $urandom}; R2_data_in = {$urandom, $urandom};
        WR_addr_in = AW'($urandom); WR_en_in = 1; mem_reg_sel_in = 1; mem_write_in = 1;
        beq_in = 1; bneq_in = 1; pc_in = IW'($urandom); branch_offset_in = IW'($urandom);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_stall", DW'(stall_out), DW'(1'b0));
        check_outputs("reset");

        reset = 0;
        exec_op(OP_ADD, 5, 7, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        check("add_lit", alu_result_out, 64'd12);

        // ALU corner cases
        exec_op(OP_SUB, 0, 1, 1, 1, 0, 0, 0, 0, 9'h010, 9'h001, 0);
        check("sub_lit", alu_result_out, 64'hFFFF_FFFF_FFFF_FFFF);
        exec_op(OP_SRA, 64'h8000_0000_0000_0000, 4, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        check("sra_lit", alu_result_out, 64'hF800_0000_0000_0000);
        exec_op(OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        check("slt_lit", alu_result_out, 64'd1);
        exec_op(OP_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        check("sltu_lit", alu_result_out, 64'd0);
        exec_op(OP_SLL, 1, 65, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        check("sll_lit", alu_result_out, 64'd2);
        exec_op(4'd15, 64'h1234, 64'h5678, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        check("ctrl15_lit", alu_result_out, 64'd0);

        // Branches
        exec_op(OP_ADD, 9, 9, 0, 0, 0, 0, 1, 0, 9'h1F0, 9'h020, 0);
        check("beq_taken_lit", DW'(branch_taken_out), 64'd1);
        check("beq_target_lit", DW'(branch_target_out), 64'h010);
        exec_op(OP_ADD, 9, 9, 0, 0, 0, 0, 0, 1, 9'h1F0, 9'h020, 0);
        check("bneq_eq_lit", DW'(branch_taken_out), 64'd0);
        exec_op(OP_SUB, 3, 4, 0, 0, 0, 0, 1, 1, 9'h005, 9'h003, 0);
        check("both_ne_lit", DW'(branch_taken_out), 64'd1);

        // Multiply, then back-to-back multiplies followed by an ADD
        exec_op(OP_MUL, 3, 64'hFFFF_FFFF_FFFF_FFFF, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        check("mul_lit", alu_result_out, 64'hFFFF_FFFF_FFFF_FFFD);
        exec_op(OP_MUL, 6, 7, 9, 1, 0, 0, 0, 0, 0, 0, 1);
        check("mul42_lit", alu_result_out, 64'd42);
        exec_op(OP_MUL, 0, 5, 10, 1, 0, 0, 0, 0, 0, 0, 0);
        check("mul0_lit", alu_result_out, 64'd0);
        exec_op(OP_ADD, 100, 23, 11, 1, 0, 0, 0, 0, 0, 0, 0);
        check("after_mul_add_lit", alu_result_out, 64'd123);

        // Reset while the multiplier is at iteration 10
        alu_ctrl_in = OP_MUL; R1_data_in = 64'h1111; R2_data_in = 64'h2222;
        WR_addr_in = 12; WR_en_in = 1; mem_reg_sel_in = 1; mem_write_in = 1;
        beq_in = 0; bneq_in = 0;
        for (int i = 0; i < 11; i++) @(negedge clk);
        check("pre_reset_stall", DW'(stall_out), DW'(1'b1));
        reset = 1;
        #1;
        check("reset_forces_stall_low", DW'(stall_out), DW'(1'b0));
        @(negedge clk);
        model_reset();
        check_outputs("mid_mul_reset");
        reset = 0;
        exec_op(OP_ADD, 1, 2, 13, 1, 0, 0, 0, 0, 0, 0, 0);

        // Random instruction stream
        for (int k = 0; k < 300; k++) begin
            rc = ($urandom_range(0, 9) == 0) ? OP_MUL : 4'($urandom_range(0, 15));
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) rb = rb & 64'hFF;
            exec_op(rc, ra, rb, AW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), IW'($urandom), IW'($urandom),
                    bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
